// File: rtl/riscv_pkg.sv
// Shared core package: data-memory region defaults and controller state encoding.
package riscv_pkg;

    localparam logic [31:0] DMEM_BASE   = 32'h0001_0000;
    localparam int unsigned DMEM_AW     = 12;
    localparam int unsigned DMEM_WCNT_W = 4;

    typedef enum logic [0:0] {
        DMEM_IDLE = 1'b0,
        DMEM_WAIT = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the LSU data port and a single-port byte-masked SRAM.
// Grants LSU requests after WAIT_CYCLES wait states, range/byte-enable checks each access,
// and returns one in-order response (valid/error/rdata) per grant, optionally through an
// extra output register (OUT_REG).
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   data_req/wr/addr/wdata/be         LSU request, held until data_gnt
//   data_gnt                          request accepted this cycle
//   data_valid/error/rdata            response, one pulse per grant
//   mem_cs/we/addr/wdata/wmask        SRAM request, driven in the grant cycle
//   mem_rdata                         SRAM read data, one cycle after mem_cs
module dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_AW      = DMEM_AW,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter bit          OUT_REG     = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_be,
    output logic              data_gnt,
    output logic [31:0]       data_rdata,
    output logic              data_valid,
    output logic              data_error,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned WCNT_W      = DMEM_WCNT_W;
    localparam logic [32:0] REGION_SIZE = 33'(4) << MEM_AW;
    // 33-bit end so a region touching the top of the address space cannot wrap.
    localparam logic [32:0] REGION_END  = {1'b0, BASE_ADDR} + REGION_SIZE;

    dmem_state_e       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              gnt_c;
    logic              err_c;

    // Out-of-region or empty byte mask.
    assign err_c = (data_addr < BASE_ADDR)
                || ({1'b0, data_addr} >= REGION_END)
                || (data_be == 4'h0);

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DMEM_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state and grant decode.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gnt_c   = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (data_req) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt_c = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                        wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            DMEM_WAIT: begin
                if (!data_req) begin
                    state_d = DMEM_IDLE;
                end else if (wcnt_q == '0) begin
                    gnt_c   = 1'b1;
                    state_d = DMEM_IDLE;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Zero-wait grant is combinational from data_req; hold it low while in reset.
    assign data_gnt  = gnt_c & reset_n;

    // SRAM side: errored accesses never select the array.
    assign mem_cs    = data_gnt & ~err_c;
    assign mem_we    = mem_cs & data_wr;
    assign mem_wmask = mem_we ? data_be : 4'h0;
    assign mem_addr  = data_addr[MEM_AW+1:2];
    assign mem_wdata = data_wdata;

    logic        rsp_vld_q, rsp_err_q, rsp_wr_q;
    logic [31:0] rsp_rdata_c;

    // First response stage, aligned with SRAM read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_wr_q  <= 1'b0;
        end else begin
            rsp_vld_q <= data_gnt;
            rsp_err_q <= err_c;
            rsp_wr_q  <= data_wr;
        end
    end

    assign rsp_rdata_c = (rsp_vld_q & ~rsp_wr_q & ~rsp_err_q) ? mem_rdata : 32'h0;

    if (OUT_REG) begin : g_out_reg
        logic        out_vld_q, out_err_q;
        logic [31:0] out_rdata_q;

        // Extra output stage; one register deep keeps full throughput.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_vld_q   <= 1'b0;
                out_err_q   <= 1'b0;
                out_rdata_q <= 32'h0;
            end else begin
                out_vld_q   <= rsp_vld_q;
                out_err_q   <= rsp_vld_q & rsp_err_q;
                out_rdata_q <= rsp_rdata_c;
            end
        end

        assign data_valid = out_vld_q;
        assign data_error = out_err_q;
        assign data_rdata = out_rdata_q;
    end else begin : g_no_out_reg
        assign data_valid = rsp_vld_q;
        assign data_error = rsp_vld_q & rsp_err_q;
        assign data_rdata = rsp_rdata_c;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: three instances (zero-wait, 3 wait states, output register),
// each with its own behavioural byte-masked SRAM array.
module tb_dmem_ctrl;

    logic        clk;
    logic        reset_n;
    logic        req   [3];
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;

    logic        gnt   [3];
    logic        valid [3];
    logic        error [3];
    logic [31:0] rdata [3];
    logic        cs    [3];
    logic        we    [3];
    logic [11:0] maddr [3];
    logic [31:0] mwdata[3];
    logic [3:0]  wmask [3];
    logic [31:0] mrdata[3];

    logic [31:0] mem [3][4096];

    int n_vec;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl #(.WAIT_CYCLES(0), .OUT_REG(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .data_req(req[0]), .data_wr(data_wr),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
        .data_gnt(gnt[0]), .data_rdata(rdata[0]), .data_valid(valid[0]), .data_error(error[0]),
        .mem_cs(cs[0]), .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_wmask(wmask[0]), .mem_rdata(mrdata[0])
    );

    dmem_ctrl #(.WAIT_CYCLES(3), .OUT_REG(1'b0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .data_req(req[1]), .data_wr(data_wr),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
        .data_gnt(gnt[1]), .data_rdata(rdata[1]), .data_valid(valid[1]), .data_error(error[1]),
        .mem_cs(cs[1]), .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_wmask(wmask[1]), .mem_rdata(mrdata[1])
    );

    dmem_ctrl #(.WAIT_CYCLES(0), .OUT_REG(1'b1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .data_req(req[2]), .data_wr(data_wr),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_be(data_be),
        .data_gnt(gnt[2]), .data_rdata(rdata[2]), .data_valid(valid[2]), .data_error(error[2]),
        .mem_cs(cs[2]), .mem_we(we[2]), .mem_addr(maddr[2]), .mem_wdata(mwdata[2]),
        .mem_wmask(wmask[2]), .mem_rdata(mrdata[2])
    );

    // Behavioural single-port SRAMs: byte-masked write, registered read.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (cs[k]) begin
                if (we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[k][b]) mem[k][maddr[k]][8*b +: 8] <= mwdata[k][8*b +: 8];
                end else begin
                    mrdata[k] <= mem[k][maddr[k]];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, settle, then checks follow.
    task automatic drv(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        req[k]     = r;
        data_wr    = w;
        data_addr  = a;
        data_wdata = d;
        data_be    = b;
        #1;
    endtask

    task automatic idle();
        drv(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        for (int i = 0; i < 3; i++) req[i] = 1'b0;
        data_wr    = 1'b0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        data_be    = 4'h0;

        // Reset values, with a request pending on the zero-wait instance.
        drv(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        check("rst_gnt",   32'(gnt[0]),   32'd0);
        check("rst_cs",    32'(cs[0]),    32'd0);
        check("rst_we",    32'(we[0]),    32'd0);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_error", 32'(error[0]), 32'd0);
        check("rst_rdata", rdata[0],      32'h0);
        check("rst_valid2", 32'(valid[2]), 32'd0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait stores: word0 = DEADBEEF, word1 = 11111111 then partial 11ABCD11.
        drv(0, 1'b1, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF);
        check("st0_gnt",   32'(gnt[0]),   32'd1);
        check("st0_cs",    32'(cs[0]),    32'd1);
        check("st0_we",    32'(we[0]),    32'd1);
        check("st0_wmask", 32'(wmask[0]), 32'hF);
        check("st0_addr",  32'(maddr[0]), 32'h0);
        drv(0, 1'b1, 1'b1, 32'h0001_0004, 32'h1111_1111, 4'hF);
        check("st1_gnt",   32'(gnt[0]),   32'd1);
        check("st0_valid", 32'(valid[0]), 32'd1);
        check("st0_rdata", rdata[0],      32'h0);
        drv(0, 1'b1, 1'b1, 32'h0001_0004, 32'h00AB_CD00, 4'b0110);
        check("st2_wmask", 32'(wmask[0]), 32'h6);
        check("st2_addr",  32'(maddr[0]), 32'h1);
        check("st1_valid", 32'(valid[0]), 32'd1);
        idle();
        check("st2_valid", 32'(valid[0]), 32'd1);
        check("st2_error", 32'(error[0]), 32'd0);
        check("st2_rdata", rdata[0],      32'h0);
        check("word0",     mem[0][0],     32'hDEAD_BEEF);
        check("word1",     mem[0][1],     32'h11AB_CD11);

        // Zero-wait load of word0.
        drv(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'hF);
        check("ld0_gnt",   32'(gnt[0]),   32'd1);
        check("ld0_we",    32'(we[0]),    32'd0);
        check("ld0_wmask", 32'(wmask[0]), 32'h0);
        check("ld0_pre_valid", 32'(valid[0]), 32'd0);
        idle();
        check("ld0_valid", 32'(valid[0]), 32'd1);
        check("ld0_rdata", rdata[0],      32'hDEAD_BEEF);
        check("ld0_error", 32'(error[0]), 32'd0);
        idle();
        check("ld0_post_valid", 32'(valid[0]), 32'd0);
        check("ld0_post_rdata", rdata[0],      32'h0);

        // Unaligned pair: two back-to-back grants and in-order responses.
        drv(0, 1'b1, 1'b0, 32'h0001_0001, 32'h0, 4'b1110);
        check("ua0_gnt",  32'(gnt[0]),   32'd1);
        check("ua0_addr", 32'(maddr[0]), 32'h0);
        drv(0, 1'b1, 1'b0, 32'h0001_0005, 32'h0, 4'b0001);
        check("ua1_gnt",   32'(gnt[0]),   32'd1);
        check("ua1_addr",  32'(maddr[0]), 32'h1);
        check("ua0_valid", 32'(valid[0]), 32'd1);
        check("ua0_rdata", rdata[0],      32'hDEAD_BEEF);
        idle();
        check("ua1_valid", 32'(valid[0]), 32'd1);
        check("ua1_rdata", rdata[0],      32'h11AB_CD11);
        idle();
        check("ua_end_valid", 32'(valid[0]), 32'd0);

        // Errors: below region, empty byte mask.
        drv(0, 1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 4'hF);
        check("lo_gnt", 32'(gnt[0]), 32'd1);
        check("lo_cs",  32'(cs[0]),  32'd0);
        drv(0, 1'b1, 1'b1, 32'h0001_0000, 32'h0, 4'h0);
        check("be0_gnt",  32'(gnt[0]),   32'd1);
        check("be0_cs",   32'(cs[0]),    32'd0);
        check("be0_we",   32'(we[0]),    32'd0);
        check("lo_valid", 32'(valid[0]), 32'd1);
        check("lo_error", 32'(error[0]), 32'd1);
        check("lo_rdata", rdata[0],      32'h0);
        idle();
        check("be0_valid", 32'(valid[0]), 32'd1);
        check("be0_error", 32'(error[0]), 32'd1);
        check("be0_word0", mem[0][0],     32'hDEAD_BEEF);

        // Upper boundary: last legal word, first word past it, top of address space.
        drv(0, 1'b1, 1'b0, 32'h0001_3FFC, 32'h0, 4'hF);
        check("last_cs",   32'(cs[0]),    32'd1);
        check("last_addr", 32'(maddr[0]), 32'hFFF);
        drv(0, 1'b1, 1'b0, 32'h0001_4000, 32'h0, 4'hF);
        check("past_cs",     32'(cs[0]),    32'd0);
        check("last_error",  32'(error[0]), 32'd0);
        drv(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);
        check("top_cs",      32'(cs[0]),    32'd0);
        check("past_error",  32'(error[0]), 32'd1);
        idle();
        check("top_error",   32'(error[0]), 32'd1);

        // Reset right after a grant drops the pending response.
        drv(0, 1'b1, 1'b0, 32'h0001_0004, 32'h0, 4'hF);
        check("rg_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        req[0]  = 1'b0;
        idle();
        check("rg_valid", 32'(valid[0]), 32'd0);
        check("rg_rdata", rdata[0],      32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        check("rg_rel_valid", 32'(valid[0]), 32'd0);
        drv(0, 1'b1, 1'b0, 32'h0001_0004, 32'h0, 4'hF);
        check("rg2_gnt", 32'(gnt[0]), 32'd1);
        idle();
        check("rg2_valid", 32'(valid[0]), 32'd1);
        check("rg2_rdata", rdata[0],      32'h11AB_CD11);

        // Three wait states: store then load at 0x0001_0008.
        for (int c = 0; c < 4; c++) begin
            drv(1, 1'b1, 1'b1, 32'h0001_0008, 32'hCAFE_F00D, 4'hF);
            check($sformatf("w3_st_gnt%0d", c), 32'(gnt[1]), 32'(c == 3));
        end
        idle();
        check("w3_st_valid", 32'(valid[1]), 32'd1);
        check("w3_st_rdata", rdata[1],      32'h0);
        for (int c = 0; c < 4; c++) begin
            drv(1, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'hF);
            check($sformatf("w3_ld_gnt%0d", c), 32'(gnt[1]), 32'(c == 3));
            check($sformatf("w3_ld_valid%0d", c), 32'(valid[1]), 32'd0);
        end
        idle();
        check("w3_ld_valid", 32'(valid[1]), 32'd1);
        check("w3_ld_rdata", rdata[1],      32'hCAFE_F00D);
        check("w3_ld_error", 32'(error[1]), 32'd0);

        // Abort: request dropped in the first wait cycle.
        drv(1, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'hF);
        check("ab_gnt0", 32'(gnt[1]), 32'd0);
        for (int c = 0; c < 5; c++) begin
            idle();
            check($sformatf("ab_gnt_idle%0d", c),   32'(gnt[1]),   32'd0);
            check($sformatf("ab_valid_idle%0d", c), 32'(valid[1]), 32'd0);
        end
        for (int c = 0; c < 4; c++) begin
            drv(1, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'hF);
            check($sformatf("ab_re_gnt%0d", c), 32'(gnt[1]), 32'(c == 3));
        end
        idle();
        check("ab_re_valid", 32'(valid[1]), 32'd1);
        check("ab_re_rdata", rdata[1],      32'hCAFE_F00D);

        // Output register: 4 back-to-back stores, then 4 back-to-back loads.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drv(2, 1'b1, 1'b1, 32'h0001_0000 + 32'(4*c), 32'(32'h0101_0101 * (c + 1)), 4'hF);
            else       idle();
            check($sformatf("or_st_gnt%0d", c),   32'(gnt[2]),   32'(c < 4));
            check($sformatf("or_st_valid%0d", c), 32'(valid[2]), 32'(c >= 2));
            check($sformatf("or_st_rdata%0d", c), rdata[2],      32'h0);
        end
        for (int c = 0; c < 7; c++) begin
            if (c < 4) drv(2, 1'b1, 1'b0, 32'h0001_0000 + 32'(4*c), 32'h0, 4'hF);
            else       idle();
            check($sformatf("or_ld_gnt%0d", c),   32'(gnt[2]),   32'(c < 4));
            check($sformatf("or_ld_valid%0d", c), 32'(valid[2]), 32'(c >= 2 && c <= 5));
            check($sformatf("or_ld_rdata%0d", c), rdata[2],
                  (c >= 2 && c <= 5) ? 32'(32'h0101_0101 * (c - 1)) : 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
